// File: rtl/gpu_pkg.sv
// Shared pixel types for the frame-buffer write path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gpu_pkg;

    localparam int PIX_ADDR_W  = 19;
    localparam int PIX_COLOR_W = 16;

    // One buffered pixel: destination frame, address within that frame, RGB565 colour.
    typedef struct packed {
        logic                   frame;
        logic [PIX_ADDR_W-1:0]  addr;
        logic [PIX_COLOR_W-1:0] color;
    } pixel_t;

    // Asynchronous-SRAM write sequence.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        WRITE = 2'd2,
        HOLD  = 2'd3
    } wr_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous pixel FIFO with occupancy count; head entry visible before pop.
// Latency: an entry pushed at edge N is the head from edge N+1 when the FIFO was empty.
// Backpressure: caller pushes only when !full or when popping in the same cycle, pops only when !empty.
module pixel_fifo
    import gpu_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   push,
    input  pixel_t                 push_dat,
    input  logic                   pop,
    output pixel_t                 head_dat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    pixel_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage array: no reset needed, entries are only read once counted valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two); count carries the extra full bit.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign head_dat = mem[rd_ptr];
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);

endmodule

// File: rtl/pixel_sram_writer.sv
// Accepts pixels from the core, buffers them, and writes each into the double-buffered async SRAM.
// Latency: capture at edge N, SETUP from edge N+1 at the earliest; WE_CYCLES+2 cycles per pixel.
// Backpressure: data_sent withheld while the FIFO is full; at most one capture per two cycles.
module pixel_sram_writer
    import gpu_pkg::*;
#(
    // ADDR_W/COLOR_W must match the pixel_t field widths in gpu_pkg.
    parameter int ADDR_W     = PIX_ADDR_W,
    parameter int COLOR_W    = PIX_COLOR_W,
    parameter int FIFO_DEPTH = 8,
    parameter int WE_CYCLES  = 2
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        data_ready,
    input  logic [ADDR_W-1:0]           address,
    input  logic [COLOR_W-1:0]          color,
    input  logic                        frame_target,
    output logic                        data_sent,
    output logic [ADDR_W:0]             sram_addr,
    output logic [COLOR_W-1:0]          sram_data,
    output logic                        sram_ce_n,
    output logic                        sram_we_n,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        idle
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int WCNT_W = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;

    pixel_t            in_pix;
    pixel_t            head_pix;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    wr_state_t         state;
    wr_state_t         state_nxt;
    logic [WCNT_W-1:0] we_cnt;
    logic [WCNT_W-1:0] we_cnt_nxt;
    logic [ADDR_W:0]   last_addr;
    logic [COLOR_W-1:0] last_data;

    // Pack the presented pixel so frame, address and colour are captured together.
    always_comb begin
        in_pix       = '0;
        in_pix.frame = frame_target;
        in_pix.addr  = address;
        in_pix.color = color;
    end

    // Head is released in HOLD; a pop in that cycle makes room for a capture even when full.
    assign fifo_pop  = (state == HOLD);
    assign fifo_push = data_ready && !data_sent && (!fifo_full || fifo_pop);

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .n_rst    (n_rst),
        .push     (fifo_push),
        .push_dat (in_pix),
        .pop      (fifo_pop),
        .head_dat (head_pix),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Acknowledge is the registered capture strobe; it also blocks a second capture of the same pixel.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            data_sent <= 1'b0;
        end else begin
            data_sent <= fifo_push;
        end
    end

    // Write-sequence state and write-enable pulse counter.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state  <= IDLE;
            we_cnt <= '0;
        end else begin
            state  <= state_nxt;
            we_cnt <= we_cnt_nxt;
        end
    end

    // Remember the last written pixel so the SRAM pins hold still while idle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            last_addr <= '0;
            last_data <= '0;
        end else if (state == HOLD) begin
            last_addr <= {head_pix.frame, head_pix.addr};
            last_data <= head_pix.color;
        end
    end

    // Next-state and SRAM pin decode; strobes come straight from the state flops so reset releases we_n at once.
    always_comb begin
        state_nxt  = state;
        we_cnt_nxt = we_cnt;
        sram_ce_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_addr  = last_addr;
        sram_data  = last_data;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                sram_ce_n  = 1'b0;
                sram_addr  = {head_pix.frame, head_pix.addr};
                sram_data  = head_pix.color;
                state_nxt  = WRITE;
                we_cnt_nxt = '0;
            end
            WRITE: begin
                sram_ce_n = 1'b0;
                sram_we_n = 1'b0;
                sram_addr = {head_pix.frame, head_pix.addr};
                sram_data = head_pix.color;
                if (we_cnt == WCNT_W'(WE_CYCLES - 1)) begin
                    state_nxt = HOLD;
                end else begin
                    we_cnt_nxt = we_cnt + 1'b1;
                end
            end
            HOLD: begin
                sram_ce_n = 1'b0;
                sram_addr = {head_pix.frame, head_pix.addr};
                sram_data = head_pix.color;
                // A pixel captured this same cycle waits one IDLE cycle before its SETUP.
                state_nxt = (fifo_count > CNT_W'(1)) ? SETUP : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign idle = (fifo_count == '0) && (state == IDLE);

endmodule

// File: tb/tb_pixel_sram_writer.sv
module tb_pixel_sram_writer;

    localparam int WE_CYCLES = 2;
    localparam int DEPTH     = 8;

    logic        tb_clk = 1'b0;
    logic        n_rst;
    logic        data_ready;
    logic [18:0] address;
    logic [15:0] color;
    logic        frame_target;
    logic        data_sent;
    logic [19:0] sram_addr;
    logic [15:0] sram_data;
    logic        sram_ce_n;
    logic        sram_we_n;
    logic [3:0]  fifo_count;
    logic        idle;

    always #5 tb_clk = ~tb_clk;

    pixel_sram_writer #(
        .ADDR_W     (19),
        .COLOR_W    (16),
        .FIFO_DEPTH (DEPTH),
        .WE_CYCLES  (WE_CYCLES)
    ) dut (
        .clk          (tb_clk),
        .n_rst        (n_rst),
        .data_ready   (data_ready),
        .address      (address),
        .color        (color),
        .frame_target (frame_target),
        .data_sent    (data_sent),
        .sram_addr    (sram_addr),
        .sram_data    (sram_data),
        .sram_ce_n    (sram_ce_n),
        .sram_we_n    (sram_we_n),
        .fifo_count   (fifo_count),
        .idle         (idle)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: pixels acknowledged but not yet seen written, as {frame, addr, color}.
    logic [35:0] exp_q[$];
    logic [35:0] seq [64];
    logic [35:0] pend;
    int          ack_cnt = 0;
    logic        last_we = 1'b1;
    logic        hold_now = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic present(input logic [35:0] p);
        frame_target = p[35];
        address      = p[34:16];
        color        = p[15:0];
        data_ready   = 1'b1;
        pend         = p;
    endtask

    // Advance to the next sampling point; an acknowledged pixel joins the expected-write queue.
    task automatic tick();
        @(negedge tb_clk);
        hold_now = n_rst && !sram_ce_n && sram_we_n && !last_we;
        last_we  = sram_we_n;
        if (data_sent && data_ready) begin
            exp_q.push_back(pend);
            ack_cnt++;
            data_ready = 1'b0;
        end
    endtask

    task automatic run_seq(input int n, input int max_gap, input int budget, input string tag);
        int idx = 1;
        int gap = 0;
        int cyc = 0;
        present(seq[0]);
        gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
        while ((idx < n || data_ready) && cyc < budget) begin
            tick();
            cyc++;
            if (!data_ready && idx < n) begin
                if (gap > 0) begin
                    gap--;
                end else begin
                    present(seq[idx]);
                    idx++;
                    gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
                end
            end
        end
        check({tag, "_budget"}, 64'(cyc < budget), 64'd1);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        for (int i = 0; i < budget && !(idle && exp_q.size() == 0); i++) begin
            tick();
        end
        check({tag, "_idle"}, 64'(idle), 64'd1);
        check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Occupancy model (accepted minus retired) and SRAM write-cycle checker.
    int          m_count = 0;
    int          m_run = 0;
    int          m_peak = 0;
    logic        m_prev_we = 1'b1;
    logic        m_prev_sent = 1'b0;
    logic        m_pop_pend = 1'b0;
    logic        m_full_block = 1'b0;
    logic [19:0] m_cur_addr = '0;
    logic [15:0] m_cur_data = '0;
    logic [35:0] m_e;

    // Every falling edge: compare occupancy, ack spacing and the SRAM strobe sequence.
    always @(negedge tb_clk) begin
        if (!n_rst) begin
            m_count      = 0;
            m_run        = 0;
            m_prev_we    = 1'b1;
            m_prev_sent  = 1'b0;
            m_pop_pend   = 1'b0;
            m_full_block = 1'b0;
        end else begin
            m_count = m_count + (data_sent ? 1 : 0) - (m_pop_pend ? 1 : 0);
            if (m_count > m_peak) m_peak = m_count;
            check("occupancy", 64'(fifo_count), 64'(m_count));
            check("idle_flag", 64'(idle), 64'((m_count == 0) && sram_ce_n));
            if (m_prev_sent) check("ack_double", 64'(data_sent), 64'd0);
            if (m_full_block) check("ack_while_full", 64'(data_sent), 64'd0);
            if (!sram_we_n) begin
                check("we_needs_ce", 64'(sram_ce_n), 64'd0);
                if (m_prev_we) begin
                    check("write_pending", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        m_e = exp_q.pop_front();
                        check("write_addr", 64'(sram_addr), 64'(m_e[35:16]));
                        check("write_data", 64'(sram_data), 64'(m_e[15:0]));
                    end
                    m_run      = 1;
                    m_cur_addr = sram_addr;
                    m_cur_data = sram_data;
                end else begin
                    m_run++;
                    check("addr_stable", 64'(sram_addr), 64'(m_cur_addr));
                    check("data_stable", 64'(sram_data), 64'(m_cur_data));
                end
            end else if (!m_prev_we) begin
                check("we_len", 64'(m_run), 64'(WE_CYCLES));
                check("hold_ce", 64'(sram_ce_n), 64'd0);
                check("hold_addr", 64'(sram_addr), 64'(m_cur_addr));
            end
            m_pop_pend   = sram_we_n && !m_prev_we;
            m_full_block = (fifo_count == 4'(DEPTH)) && !m_pop_pend;
            m_prev_we    = sram_we_n;
            m_prev_sent  = data_sent;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish, expected finish before 400000 ns");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r;
        int          acks_before;
        int          nxt;
        logic        hit;

        n_rst        = 1'b0;
        data_ready   = 1'b0;
        address      = '0;
        color        = '0;
        frame_target = 1'b0;
        #1;
        check("rst_data_sent", 64'(data_sent), 64'd0);
        check("rst_ce_n", 64'(sram_ce_n), 64'd1);
        check("rst_we_n", 64'(sram_we_n), 64'd1);
        check("rst_addr", 64'(sram_addr), 64'd0);
        check("rst_data", 64'(sram_data), 64'd0);
        check("rst_count", 64'(fifo_count), 64'd0);
        check("rst_idle", 64'(idle), 64'd1);
        tick();
        tick();
        #2 n_rst = 1'b1;
        tick();

        // Single pixel into frame 1.
        present({1'b1, 19'h00123, 16'hF800});
        tick();
        check("single_ack", 64'(data_sent), 64'd1);
        tick();
        check("single_ack_pulse", 64'(data_sent), 64'd0);
        for (int i = 0; i < 4 && !idle; i++) tick();
        check("single_idle5", 64'(idle), 64'd1);
        check("single_addr", 64'(sram_addr), 64'h80123);
        check("single_data", 64'(sram_data), 64'hF800);
        wait_idle(20, "single");

        // data_ready held on one pixel for 6 cycles: one capture every other cycle.
        r = $urandom;
        acks_before = ack_cnt;
        present({r[0], r[19:1], r[31:16]});
        for (int i = 0; i < 6; i++) begin
            tick();
            if (!data_ready) present(pend);
        end
        data_ready = 1'b0;
        check("held_acks", 64'(ack_cnt - acks_before), 64'd3);
        wait_idle(60, "held");

        // Fill: 20 back-to-back pixels, addresses and colours 0..19, must saturate the FIFO.
        m_peak = 0;
        for (int i = 0; i < 20; i++) seq[i] = {1'b0, 19'(i), 16'(i)};
        run_seq(20, 0, 400, "fill");
        check("fill_peak", 64'(m_peak), 64'(DEPTH));
        wait_idle(100, "fill");

        // Frame select on the top address.
        for (int i = 0; i < 4; i++) begin
            r = $urandom;
            seq[i] = {1'(i % 2), 19'h7FFFF, r[15:0]};
        end
        run_seq(4, 0, 100, "frame");
        wait_idle(60, "frame");
        check("frame_last_addr", 64'(sram_addr), 64'hFFFFF);

        // Random pixels with random gaps between presentations.
        for (int i = 0; i < 40; i++) begin
            r = $urandom;
            seq[i] = {r[31], r[30:12], r[15:0] ^ r[31:16]};
        end
        run_seq(40, 3, 800, "rand");
        wait_idle(200, "rand");

        // Push/pop collision: capture lands on a HOLD pop with three entries buffered.
        hit = 1'b0;
        nxt = 100;
        for (int cyc = 0; cyc < 400 && !hit; cyc++) begin
            if (!data_ready && !data_sent) begin
                if (hold_now && fifo_count == 4'd3) begin
                    present({1'b0, 19'(nxt), 16'(nxt)});
                    nxt++;
                    hit = 1'b1;
                end else if (fifo_count < 4'd3) begin
                    present({1'b1, 19'(nxt), 16'(nxt)});
                    nxt++;
                end
            end
            tick();
        end
        check("collide_found", 64'(hit), 64'd1);
        check("collide_count", 64'(fifo_count), 64'd3);
        check("collide_ack", 64'(data_sent), 64'd1);
        wait_idle(100, "collide");

        // Reset in the middle of a write strobe.
        for (int i = 0; i < 3; i++) begin
            r = $urandom;
            seq[i] = {r[0], r[19:1], r[31:16]};
        end
        run_seq(3, 0, 50, "prerst");
        for (int i = 0; i < 20 && sram_we_n; i++) tick();
        check("rst_in_write", 64'(sram_we_n), 64'd0);
        #2 n_rst = 1'b0;
        #1;
        check("arst_we_n", 64'(sram_we_n), 64'd1);
        check("arst_ce_n", 64'(sram_ce_n), 64'd1);
        check("arst_idle", 64'(idle), 64'd1);
        check("arst_addr", 64'(sram_addr), 64'd0);
        data_ready = 1'b0;
        exp_q.delete();
        tick();
        tick();
        #2 n_rst = 1'b1;
        last_we = 1'b1;
        tick();
        check("post_rst_count", 64'(fifo_count), 64'd0);
        check("post_rst_idle", 64'(idle), 64'd1);

        // Buffered pixels were discarded; a fresh pixel still goes through.
        seq[0] = {1'b0, 19'h00042, 16'h07E0};
        run_seq(1, 0, 20, "post_rst");
        wait_idle(20, "post_rst");
        check("post_rst_addr", 64'(sram_addr), 64'h00042);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
